// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI receive -> FIFO write path.
package spi_rx_pkg;

  // Receiver FSM: waiting for chip select, or shifting a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the dropped-word counter.
  localparam int DROP_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo_writer_if.sv
// FIFO write-side bundle: strobe and data towards the FIFO, full flag back.
interface spi_rx_fifo_writer_if #(
  parameter int WIDTH = 20
);
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             wrfull;

  modport master (output wrreq, output data, input wrfull);
  modport slave  (input wrreq, input data, output wrfull);
endinterface

// File: rtl/spi_in_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value, so each
// SPI pin can come out of reset at its idle level.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic wrclk,
  input  logic aclr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw pin into the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain flops; reset puts every stage at the pin's idle level.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) sync_q <= {STAGES{RST_VAL}};
    else      sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_rx_fifo_writer.sv
// SPI (mode 0) slave receiver that packs WIDTH-bit words and writes them into
// a FIFO. A single pending buffer absorbs one word while the FIFO is full;
// further words are dropped and flagged.
// Optional feature: define SPI_RX_DROP_CNT_EN to build the saturating
// dropped-word counter; otherwise drop_cnt reads as zero.
module spi_rx_fifo_writer
  import spi_rx_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wrclk,
  input  logic                  aclr,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  clr_ovf,
  spi_rx_fifo_writer_if.master  fifo,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_s, cs_n_s, mosi_s;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .wrclk(wrclk), .aclr(aclr), .d(sclk), .q(sclk_s));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .wrclk(wrclk), .aclr(aclr), .d(cs_n), .q(cs_n_s));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .wrclk(wrclk), .aclr(aclr), .d(mosi), .q(mosi_s));

  state_e           state_q, state_d;
  logic             sclk_prev_q, sclk_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             wr_last_q, wr_last_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic             rise;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             push;
  logic             drop;

  // Next-state logic: edge detect, bit shifting, word hand-off and overflow.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    word        = shift_q;
    drop        = 1'b0;

    sclk_prev_d = sclk_s;
    rise        = sclk_s & ~sclk_prev_q;

    case (state_q)
      IDLE: begin
        // sclk activity outside a frame is ignored.
        if (!cs_n_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_n_s) begin
          // End of frame: any partial word is thrown away.
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          shift_d     = '0;
        end else if (rise) begin
          shift_d = {shift_q[WIDTH-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            cnt_d     = '0;
            word_done = 1'b1;
            word      = shift_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);

    // The pending word is offered whenever the FIFO has room; a one-cycle
    // holdoff after each write keeps strobes from landing back to back.
    push       = pend_vld_q & ~fifo.wrfull & ~wr_last_q;
    wr_last_d  = push;
    pend_vld_d = pend_vld_q & ~push;

    // A word finishing in the same cycle the buffer drains takes its place.
    if (word_done) begin
      if (pend_vld_d) begin
        drop = 1'b1;
      end else begin
        pend_d     = word;
        pend_vld_d = 1'b1;
      end
    end

    // A drop wins over a simultaneous clear.
    overflow_d = drop | (overflow_q & ~clr_ovf);
  end

  // State and output registers.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      wr_last_q   <= wr_last_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_RX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Count dropped words, holding at the maximum.
  always_comb begin
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // Dropped-word counter register.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign fifo.wrreq = push;
  assign fifo.data  = pend_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule
